multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have a single clock domain; reset is synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-low reset; 0 = reset.
REQ-004 op  input  2  instruction op field, from the instruction register.
REQ-005 funct  input  6  funct field; funct[5] = I (immediate), funct[0] = L (load) or S.
REQ-006 rd_is_pc  input  1  destination register is R15.
REQ-007 cond_ex  input  1  condition passed; valid in all states after FETCH.
REQ-008 mem_ready  input  1  memory completes the access this cycle.
REQ-009 pc_write, ir_write, reg_write, mem_write  output  1 each  gated enables to the PC, IR, register-file and memory enable registers.
REQ-010 adr_src  output  1  memory address mux select; 0 = PC, 1 = ALU result.
REQ-011 alu_src_a  output  1  ALU A select; 0 = register, 1 = PC.
REQ-012 alu_src_b  output  2  ALU B select; 00 = register, 01 = immediate, 10 = constant 4.
REQ-013 result_src  output  2  result mux select; 00 = ALUOut, 01 = Data, 10 = ALU direct.
REQ-014 alu_op  output  1  1 = ALU decoder uses funct; 0 = forced add.
REQ-015 state  output  4  current state encoding, for debug.

Function
REQ-016 The block SHALL be a Moore FSM with these state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9.
REQ-017 Codes 10-15 SHALL transition to FETCH on the next edge, and SHALL drive all enables to 0.
REQ-018 FETCH SHALL stay in FETCH while mem_ready=0; it SHALL go to DECODE when mem_ready=1.
REQ-019 DECODE transitions SHALL be as follows:
- op=01 -> MEMADR
- op=00 and funct[5]=0 -> EXECR
- op=00 and funct[5]=1 -> EXECI
- op=10 -> BRANCH
- op=11 -> FETCH (undefined instruction, no writes)
REQ-020 MEMADR SHALL go to MEMRD if funct[0]=1, and to MEMWR otherwise.
REQ-021 MEMRD SHALL hold while mem_ready=0 and go to MEMWB when mem_ready=1.
REQ-022 MEMWR SHALL hold while mem_ready=0 and go to FETCH when mem_ready=1.
REQ-023 The remaining transitions SHALL be: MEMWB -> FETCH; EXECR and EXECI -> ALUWB; ALUWB -> FETCH; BRANCH -> FETCH; each is unconditional.
REQ-024 Selects per state SHALL be as follows (unlisted selects = 0):
- FETCH: alu_src_a=1, alu_src_b=10, result_src=10
- DECODE: alu_src_a=1, alu_src_b=10, result_src=10
- MEMADR: alu_src_b=01
- MEMRD: adr_src=1
- MEMWB: result_src=01
- MEMWR: adr_src=1
- EXECR: alu_op=1
- EXECI: alu_op=1, alu_src_b=01
- BRANCH: alu_src_b=01, result_src=10
REQ-025 ir_write SHALL equal 1 only in FETCH and only when mem_ready=1.
REQ-026 Raw enables SHALL be: next_pc in FETCH; regw in MEMWB and ALUWB; memw in MEMWR; br in BRANCH.
REQ-027 The gated enables SHALL be combinational from the state and the inputs:
- reg_write = regw & cond_ex & ~rd_is_pc
- mem_write = memw & cond_ex & mem_ready
- pc_write = (next_pc & mem_ready) | (br & cond_ex) | (regw & cond_ex & rd_is_pc)
REQ-028 mem_write SHALL be asserted for exactly one cycle per store, namely the mem_ready cycle.
REQ-029 A failed condition (cond_ex=0) SHALL still traverse the full state path, with no register, memory or PC write.
REQ-030 Instruction latency SHALL be counted with zero memory wait states; each wait cycle adds 1 cycle in FETCH, MEMRD or MEMWR:
- load: 5 cycles
- store: 4 cycles
- data-processing: 4 cycles
- branch: 3 cycles

Reset
REQ-031 When reset=0 at a rising edge, state SHALL become FETCH.
REQ-032 While reset=0, pc_write, ir_write, reg_write and mem_write SHALL be forced to 0 regardless of state.
REQ-033 Reset asserted in any state, including wait states, SHALL abort the instruction; no enable SHALL fire on that edge or during reset.
REQ-034 The first cycle after reset release SHALL be FETCH with the FETCH select values from REQ-024.

Verification
REQ-035 The bench SHALL cover the following directed scenarios:
- Zero-wait LDR: op=01, funct=000001, cond_ex=1, mem_ready=1 -> state 0,1,2,3,4,0; reg_write=1 only in state 4; pc_write=1 only in state 0.
- STR with 2 wait cycles: op=01, funct[0]=0, mem_ready=0 for 2 cycles in MEMWR -> state 5 held 3 cycles; mem_write=1 only in the third cycle.
- ADD immediate to R15: op=00, funct[5]=1, rd_is_pc=1 -> states 0,1,7,8; in state 8 reg_write=0 and pc_write=1.
- Branch with cond_ex=0: op=10 -> states 0,1,9,0; pc_write=0 in state 9; no write enable high in 9.
- FETCH stall then reset: mem_ready=0 for 5 cycles -> ir_write=0 throughout; reset=0 on cycle 3 -> state 0; all enables 0 while reset low.
- Undefined op=11 -> DECODE goes to FETCH; no writes; illegal state forced via force/release -> FETCH next edge.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle ARM-like datapath.
// Selects are registered from the next state; write enables are gated combinationally.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic       rd_is_pc,
    input  logic       cond_ex,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       adr_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       alu_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [6:0] r_sel;
    logic       w_next_pc;
    logic       w_regw;
    logic       w_memw;
    logic       w_br;
    logic       w_unused;

    // Select bundle ordering: {adr_src, alu_src_a, alu_src_b, result_src, alu_op}
    function automatic logic [6:0] selsFor(input logic [3:0] s);
        selsFor = 7'b0;
        case (s)
            S_FETCH, S_DECODE: selsFor = 7'b0_1_10_10_0;
            S_MEMADR:          selsFor = 7'b0_0_01_00_0;
            S_MEMRD:           selsFor = 7'b1_0_00_00_0;
            S_MEMWB:           selsFor = 7'b0_0_00_01_0;
            S_MEMWR:           selsFor = 7'b1_0_00_00_0;
            S_EXECR:           selsFor = 7'b0_0_00_00_1;
            S_EXECI:           selsFor = 7'b0_0_01_00_1;
            S_BRANCH:          selsFor = 7'b0_0_01_10_0;
            default:           selsFor = 7'b0;
        endcase
    endfunction

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    2'b01:   w_next = S_MEMADR;
                    2'b00:   w_next = funct[5] ? S_EXECI : S_EXECR;
                    2'b10:   w_next = S_BRANCH;
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_next = funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
            S_MEMWB:  w_next = S_FETCH;
            S_EXECR:  w_next = S_ALUWB;
            S_EXECI:  w_next = S_ALUWB;
            S_ALUWB:  w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            default:  w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_sel   <= selsFor(S_FETCH);
        end else begin
            r_state <= w_next;
            r_sel   <= selsFor(w_next);
        end
    end

    assign w_next_pc = (r_state == S_FETCH);
    assign w_regw    = (r_state == S_MEMWB) || (r_state == S_ALUWB);
    assign w_memw    = (r_state == S_MEMWR);
    assign w_br      = (r_state == S_BRANCH);

    // Holding reset low kills every enable, even mid-instruction.
    assign ir_write  = reset & w_next_pc & mem_ready;
    assign reg_write = reset & w_regw & cond_ex & ~rd_is_pc;
    assign mem_write = reset & w_memw & cond_ex & mem_ready;
    assign pc_write  = reset & ((w_next_pc & mem_ready) | (w_br & cond_ex)
                                | (w_regw & cond_ex & rd_is_pc));

    assign {adr_src, alu_src_a, alu_src_b, result_src, alu_op} = r_sel;
    assign state    = r_state;
    assign w_unused = ^funct[4:1];

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-instruction step model pushes expected
// cycles into a queue, a negedge monitor pops and compares the DUT outputs.
module tb_multicycle_ctrl;

    localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4;
    localparam int MEMWR = 5, EXECR = 6, EXECI = 7, ALUWB = 8, BRANCH = 9;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] op;
    logic [5:0] funct;
    logic       rd_is_pc, cond_ex, mem_ready;
    logic       pc_write, ir_write, reg_write, mem_write;
    logic       adr_src, alu_src_a, alu_op;
    logic [1:0] alu_src_b, result_src;
    logic [3:0] state;

    typedef struct {
        logic [14:0] v;
        int          tag;
    } exp_t;

    exp_t expQ[$];
    int   total = 0;
    int   bad   = 0;
    int   instTag = 0;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .rd_is_pc(rd_is_pc),
        .cond_ex(cond_ex), .mem_ready(mem_ready), .pc_write(pc_write),
        .ir_write(ir_write), .reg_write(reg_write), .mem_write(mem_write),
        .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .alu_op(alu_op), .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] selFor(input int s);
        logic       adr, srcA, aop;
        logic [1:0] srcB, res;
        adr = 0; srcA = 0; aop = 0; srcB = 2'b00; res = 2'b00;
        if (s == FETCH || s == DECODE) begin srcA = 1; srcB = 2'b10; res = 2'b10; end
        if (s == MEMADR) srcB = 2'b01;
        if (s == MEMRD || s == MEMWR) adr = 1;
        if (s == MEMWB) res = 2'b01;
        if (s == EXECR || s == EXECI) aop = 1;
        if (s == EXECI || s == BRANCH) srcB = 2'b01;
        if (s == BRANCH) res = 2'b10;
        return {adr, srcA, srcB, res, aop};
    endfunction

    function automatic logic [14:0] mk(input int s, input logic pcw, irw, rw, mw);
        return {4'(s), pcw, irw, rw, mw, selFor(s)};
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [14:0] act;
        if (expQ.size() > 0) begin
            e   = expQ.pop_front();
            act = {state, pc_write, ir_write, reg_write, mem_write,
                   adr_src, alu_src_a, alu_src_b, result_src, alu_op};
            total++;
            if (act !== e.v) begin
                bad++;
                $display("[TB] FAIL cycle inst=%0d got st=%0d en=%b sel=%b expected st=%0d en=%b sel=%b",
                         e.tag, act[14:11], act[10:7], act[6:0], e.v[14:11], e.v[10:7], e.v[6:0]);
            end
        end
    end

    task automatic pushExp(input logic [14:0] v);
        exp_t e;
        e.v   = v;
        e.tag = instTag;
        expQ.push_back(e);
    endtask

    // One instruction: the step list comes from the instruction class and wait counts.
    task automatic applyStimulus(input logic [1:0] iOp, input logic [5:0] iFunct,
                                 input logic iRdPc, input logic iCond,
                                 input int fw, input int mw, input int abortAt, input int rstLen);
        int   sts[$];
        logic mrs[$];
        int   s;
        logic pcw, irw, rw, mwr;
        instTag++;
        for (int k = 0; k < fw; k++) begin sts.push_back(FETCH); mrs.push_back(1'b0); end
        sts.push_back(FETCH);  mrs.push_back(1'b1);
        sts.push_back(DECODE); mrs.push_back(1'($urandom_range(0, 1)));
        case (iOp)
            2'b01: begin
                sts.push_back(MEMADR); mrs.push_back(1'($urandom_range(0, 1)));
                s = iFunct[0] ? MEMRD : MEMWR;
                for (int k = 0; k < mw; k++) begin sts.push_back(s); mrs.push_back(1'b0); end
                sts.push_back(s); mrs.push_back(1'b1);
                if (iFunct[0]) begin sts.push_back(MEMWB); mrs.push_back(1'($urandom_range(0, 1))); end
            end
            2'b00: begin
                sts.push_back(iFunct[5] ? EXECI : EXECR); mrs.push_back(1'($urandom_range(0, 1)));
                sts.push_back(ALUWB); mrs.push_back(1'($urandom_range(0, 1)));
            end
            2'b10: begin sts.push_back(BRANCH); mrs.push_back(1'($urandom_range(0, 1))); end
            default: ;
        endcase
        op = iOp; funct = iFunct;
        for (int i = 0; i < sts.size(); i++) begin
            if (i == abortAt) begin
                for (int r = 0; r < rstLen; r++) begin
                    reset     = 1'b0;
                    mem_ready = (r == 0) ? mrs[i] : 1'($urandom_range(0, 1));
                    cond_ex   = 1'b1;
                    rd_is_pc  = 1'($urandom_range(0, 1));
                    pushExp(mk((r == 0) ? sts[i] : FETCH, 0, 0, 0, 0));
                    @(posedge clk); #1;
                end
                reset = 1'b1;
                return;
            end
            reset = 1'b1; rd_is_pc = iRdPc; cond_ex = iCond; mem_ready = mrs[i];
            s = sts[i];
            pcw = 0; irw = 0; rw = 0; mwr = 0;
            if (s == FETCH && mrs[i]) begin irw = 1; pcw = 1; end
            if (s == MEMWB || s == ALUWB) begin rw = iCond & ~iRdPc; pcw = iCond & iRdPc; end
            if (s == MEMWR && mrs[i]) mwr = iCond;
            if (s == BRANCH) pcw = iCond;
            pushExp(mk(s, pcw, irw, rw, mwr));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int abortAt;
        reset = 1'b0; op = 2'b00; funct = 6'd0; rd_is_pc = 1'b1; cond_ex = 1'b1; mem_ready = 1'b1;
        @(posedge clk); #1;
        for (int r = 0; r < 3; r++) begin
            pushExp(mk(FETCH, 0, 0, 0, 0));
            @(posedge clk); #1;
        end

        applyStimulus(2'b01, 6'b000001, 1'b0, 1'b1, 0, 0, -1, 0);
        applyStimulus(2'b01, 6'b000000, 1'b0, 1'b1, 0, 2, -1, 0);
        applyStimulus(2'b00, 6'b100000, 1'b1, 1'b1, 0, 0, -1, 0);
        applyStimulus(2'b10, 6'b000000, 1'b0, 1'b0, 0, 0, -1, 0);
        applyStimulus(2'b00, 6'b000000, 1'b0, 1'b1, 5, 0, 2, 3);
        applyStimulus(2'b11, 6'b101011, 1'b1, 1'b1, 0, 0, -1, 0);

        for (int code = 10; code < 16; code++) begin
            reset = 1'b1; cond_ex = 1'b1; mem_ready = 1'b1; rd_is_pc = 1'b1;
            op = 2'b10; funct = 6'b100001;
            force dut.r_state = 4'(code);
            #2;
            checkOutput("illegal_enables", 16'({pc_write, ir_write, reg_write, mem_write}), 16'h0);
            release dut.r_state;
            @(posedge clk); #1;
            checkOutput("illegal_next", 16'(state), 16'h0);
        end

        for (int n = 0; n < 250; n++) begin
            abortAt = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 7)) : -1;
            applyStimulus(2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                          abortAt, int'($urandom_range(1, 2)));
        end

        repeat (2) @(negedge clk);
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain: %0d expected entries left, required 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
